// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - data-memory ready/valid bus between the MEM stage and memory
//
// Signals:
//   dmem_req    request, held until dmem_ready or the stage gives up
//   dmem_we     1 = write, 0 = read
//   dmem_addr   word-aligned byte address
//   dmem_be     byte enables (all ones for reads)
//   dmem_wdata  lane-replicated store data
//   dmem_rdata  read data, valid when dmem_ready=1
//   dmem_ready  access completes this cycle
// Modports: master (MEM stage), slave (memory).

interface memory_cycle_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RV32I MEM stage: load/store bus access, stall, MEM/WB register
//
// Purpose: issues loads/stores from the EX/MEM register onto the data-memory bus,
// steers byte lanes, extends load data, stalls on wait states, flags misaligned
// accesses and bus timeouts, and registers the MEM/WB state.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   ValidM .. PCPlus4M       EX/MEM register outputs (held stable while StallM=1)
//   dmem                     data-memory bus (master side)
//   StallM                   freeze upstream stages this cycle
//   RegWriteW .. BusErrW     registered MEM/WB outputs
// Parameter MAX_WAIT: cycles a request may wait for dmem_ready (1..255).

module memory_cycle #(
  parameter int MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ValidM,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           Funct3M,
  input  logic [4:0]           RD_M,
  input  logic [31:0]          ALU_ResultM,
  input  logic [31:0]          WriteDataM,
  input  logic [31:0]          PCPlus4M,
  memory_cycle_if.master       dmem,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RD_W,
  output logic [31:0]          ALU_ResultW,
  output logic [31:0]          ReadDataW,
  output logic [31:0]          PCPlus4W,
  output logic                 MisalignW,
  output logic                 BusErrW
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_next;
  logic [7:0]  wcnt, wcnt_next;
  logic        stall, timeout;

  logic        is_load, acc, mis, req;
  logic        byte_sz, half_sz;
  logic [1:0]  off;
  logic [31:0] lane_word, load_ext;

  assign off     = ALU_ResultM[1:0];
  assign is_load = (ResultSrcM == 2'b01);
  assign acc     = ValidM & (MemWriteM | is_load);

  // Store and load encodings disagree on 100/101, so size decoding depends on direction.
  // Unlisted Funct3 values fall through to a word access.
  always_comb begin
    byte_sz = 1'b0;
    half_sz = 1'b0;
    if (MemWriteM) begin
      byte_sz = (Funct3M == 3'b000);
      half_sz = (Funct3M == 3'b001);
    end else begin
      byte_sz = (Funct3M == 3'b000) | (Funct3M == 3'b100);
      half_sz = (Funct3M == 3'b001) | (Funct3M == 3'b101);
    end
  end

  assign mis = acc & ((half_sz & off[0]) | (~byte_sz & ~half_sz & (off != 2'b00)));
  assign req = acc & ~mis & ~rst;

  assign dmem.dmem_req  = req;
  assign dmem.dmem_we   = MemWriteM;
  assign dmem.dmem_addr = {ALU_ResultM[31:2], 2'b00};

  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      if (byte_sz) begin
        dmem.dmem_be    = 4'b0001 << off;
        dmem.dmem_wdata = {4{WriteDataM[7:0]}};
      end else if (half_sz) begin
        dmem.dmem_be    = 4'b0011 << off;
        dmem.dmem_wdata = {2{WriteDataM[15:0]}};
      end
    end
  end

  // Shift the addressed byte/half down to bit 0 before extending.
  assign lane_word = dmem.dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (Funct3M)
      3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_ext = {24'd0, lane_word[7:0]};
      3'b101:  load_ext = {16'd0, lane_word[15:0]};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= 8'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    stall      = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !dmem.dmem_ready) begin
          state_next = WAIT;
          wcnt_next  = 8'd1;
          stall      = 1'b1;
        end
      end
      WAIT: begin
        if (!req || dmem.dmem_ready) begin
          // ready wins over a coincident timeout
          state_next = IDLE;
          wcnt_next  = 8'd0;
        end else if (wcnt >= 8'(MAX_WAIT - 1)) begin
          state_next = IDLE;
          wcnt_next  = 8'd0;
          timeout    = 1'b1;
        end else begin
          wcnt_next  = wcnt + 8'd1;
          stall      = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        wcnt_next  = 8'd0;
      end
    endcase
  end

  assign StallM = stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= 5'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
      PCPlus4W    <= 32'd0;
      MisalignW   <= 1'b0;
      BusErrW     <= 1'b0;
    end else if (StallM) begin
      // bubble into writeback; data fields hold
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      RegWriteW   <= ValidM & RegWriteM & ~mis & ~timeout;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (acc & is_load & ~MemWriteM & ~mis & ~timeout) ? load_ext : 32'd0;
      PCPlus4W    <= PCPlus4M;
      MisalignW   <= mis;
      BusErrW     <= timeout;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - scoreboard testbench for memory_cycle

module tb_memory_cycle;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ValidM = 1'b0, RegWriteM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [2:0]  Funct3M = 3'b000;
  logic [4:0]  RD_M = 5'd0;
  logic [31:0] ALU_ResultM = 32'd0, WriteDataM = 32'd0, PCPlus4M = 32'd0;
  logic        StallM, RegWriteW, MisalignW, BusErrW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

  memory_cycle_if dmem();

  memory_cycle #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .dmem(dmem.master), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regwrite;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  // Monitor: a stage that did not stall at a negedge commits at the next posedge.
  initial begin
    bit   s, have, en;
    exp_t e;
    forever begin
      @(negedge clk);
      s = StallM;
      en = mon_en && !rst;
      have = sb.size() > 0;
      @(posedge clk);
      #1;
      if (en) begin
        if (s) begin
          checks++;
          if (RegWriteW !== 1'b0 || ResultSrcW !== 2'b00 || MisalignW !== 1'b0 || BusErrW !== 1'b0) begin
            errors++;
            $display("FAIL stall_bubble got rw=%b rs=%b mis=%b berr=%b want all 0",
                     RegWriteW, ResultSrcW, MisalignW, BusErrW);
          end
        end else if (have) begin
          e = sb.pop_front();
          checks++;
          if ({RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W, MisalignW, BusErrW} !==
              {e.regwrite, e.rsrc, e.rd, e.alu, e.pc4, e.mis, e.berr} ||
              (e.chk_rdata && ReadDataW !== e.rdata)) begin
            errors++;
            $display("FAIL wb_commit got rw=%b rs=%b rd=%0d alu=%h pc4=%h rdata=%h mis=%b berr=%b want rw=%b rs=%b rd=%0d alu=%h pc4=%h rdata=%h(chk=%b) mis=%b berr=%b",
                     RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W, ReadDataW, MisalignW, BusErrW,
                     e.regwrite, e.rsrc, e.rd, e.alu, e.pc4, e.rdata, e.chk_rdata, e.mis, e.berr);
          end
        end
      end
    end
  end

  // Drive one instruction; memory answers after k wait cycles (never if k >= MAX_WAIT).
  task automatic issue(input logic v, input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc4, input logic [31:0] rdv,
                       input int k);
    exp_t        e;
    bit          acc, load, mis, tmo;
    int          nbytes, off, stalls;
    logic [31:0] lanev, val, exp_wdata;
    logic [3:0]  exp_be;
    acc  = v && (mw || rs == 2'b01);
    load = (rs == 2'b01) && !mw;
    if (mw) nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    off    = int'(a % 4);
    mis    = acc && (off % nbytes != 0);
    tmo    = acc && !mis && (k >= MAX_WAIT);
    stalls = (acc && !mis) ? (tmo ? MAX_WAIT - 1 : k) : 0;
    lanev  = rdv >> (8 * off);
    if (nbytes == 1) begin
      val = lanev & 32'hFF;
      if (f3 == 3'd0 && val >= 32'd128) val = val | 32'hFFFFFF00;
    end else if (nbytes == 2) begin
      val = lanev & 32'hFFFF;
      if (f3 == 3'd1 && val >= 32'd32768) val = val | 32'hFFFF0000;
    end else begin
      val = rdv;
    end
    exp_be    = mw ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
    exp_wdata = (nbytes == 1) ? (wd & 32'hFF) * 32'h01010101 :
                (nbytes == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    e.regwrite  = v && rw && !mis && !tmo;
    e.rsrc      = rs;
    e.rd        = rd;
    e.alu       = a;
    e.pc4       = pc4;
    e.rdata     = acc ? val : 32'd0;
    e.chk_rdata = !acc || (load && !mis && !tmo);
    e.mis       = mis;
    e.berr      = tmo;

    @(posedge clk);
    #1;
    ValidM = v; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3;
    RD_M = rd; ALU_ResultM = a; WriteDataM = wd; PCPlus4M = pc4;
    sb.push_back(e);
    for (int c = 0; c <= stalls; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      dmem.dmem_ready = (c == k);
      dmem.dmem_rdata = (c == k) ? rdv : $urandom;
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (dmem.dmem_req !== (acc && !mis)) begin
          errors++;
          $display("FAIL bus_req got %b want %b (a=%h f3=%0d mw=%b)", dmem.dmem_req, acc && !mis, a, f3, mw);
        end
        if (acc && !mis) begin
          checks++;
          if (dmem.dmem_we !== mw || dmem.dmem_addr !== (a - 32'(off)) || dmem.dmem_be !== exp_be ||
              (mw && dmem.dmem_wdata !== exp_wdata)) begin
            errors++;
            $display("FAIL bus_fields got we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                     dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata,
                     mw, a - 32'(off), exp_be, exp_wdata);
          end
        end
      end
      checks++;
      if (StallM !== (c < stalls)) begin
        errors++;
        $display("FAIL stall_cycle%0d got %b want %b", c, StallM, c < stalls);
      end
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic        v, rw, mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a, wd, pc4, rdv;
    int          k, t;

    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'd0;
    // a load presented during reset must not reach the bus
    ValidM = 1'b1; ResultSrcM = 2'b01; Funct3M = 3'b010; ALU_ResultM = 32'h40;
    #2;
    checks++;
    if ({RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW, BusErrW} !== '0 ||
        dmem.dmem_req !== 1'b0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got req=%b stall=%b rw=%b alu=%h rdata=%h want all 0",
               dmem.dmem_req, StallM, RegWriteW, ALU_ResultW, ReadDataW);
    end
    repeat (2) @(posedge clk);
    ValidM = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    issue(1, 0, 1, 2'b00, 3'b010, 5'd1, 32'h100, 32'hDEADBEEF, 32'h1004, 32'h0, 0);       // SW
    issue(1, 1, 0, 2'b01, 3'b000, 5'd2, 32'h203, 32'h0, 32'h1008, 32'h80FFFF7F, 0);       // LB
    issue(1, 1, 0, 2'b01, 3'b100, 5'd3, 32'h203, 32'h0, 32'h100C, 32'h80FFFF7F, 0);       // LBU
    issue(1, 1, 0, 2'b01, 3'b101, 5'd4, 32'h202, 32'h0, 32'h1010, 32'h80FFFF7F, 0);       // LHU
    issue(1, 0, 1, 2'b00, 3'b001, 5'd5, 32'h12, 32'h0000ABCD, 32'h1014, 32'h0, 0);        // SH
    issue(1, 1, 0, 2'b01, 3'b010, 5'd6, 32'h300, 32'h0, 32'h1018, 32'h12345678, 3);       // LW, 3 waits
    issue(1, 1, 0, 2'b01, 3'b010, 5'd7, 32'h106, 32'h0, 32'h101C, 32'h0, 0);              // LW misaligned
    issue(1, 1, 0, 2'b01, 3'b010, 5'd8, 32'h400, 32'h0, 32'h1020, 32'h0, 99);             // LW timeout
    issue(1, 1, 0, 2'b01, 3'b010, 5'd9, 32'h404, 32'h0, 32'h1024, 32'hCAFEF00D, MAX_WAIT - 1); // ready at last chance

    // reset in the middle of a wait
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    ValidM = 1'b1; RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010;
    RD_M = 5'd10; ALU_ResultM = 32'h500; PCPlus4M = 32'h2000;
    dmem.dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (StallM !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_stall got %b want 1", StallM);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dmem.dmem_req !== 1'b0 || StallM !== 1'b0 ||
        {RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW, BusErrW} !== '0) begin
      errors++;
      $display("FAIL mid_wait_reset got req=%b stall=%b rw=%b rs=%b alu=%h berr=%b want all 0",
               dmem.dmem_req, StallM, RegWriteW, ResultSrcW, ALU_ResultW, BusErrW);
    end
    ValidM = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(1, 1, 0, 2'b01, 3'b010, 5'd11, 32'h504, 32'h0, 32'h2004, 32'h0BADF00D, 1);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      t   = $urandom_range(0, 4);
      rd  = 5'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd  = $urandom;
      pc4 = $urandom;
      rdv = $urandom;
      k   = $urandom_range(0, 5);
      f3  = 3'($urandom_range(0, 7));
      case (t)
        0: begin
          v = 1'b1; rw = 1'($urandom_range(0, 1)); mw = 1'b0;
          rs = 2'($urandom_range(0, 2));
          if (rs == 2'b01) rs = 2'b11;
        end
        2: begin
          v = 1'b1; rw = 1'b0; mw = 1'b1; rs = 2'b00;
        end
        3: begin
          v = 1'b0; rw = 1'b0; mw = 1'($urandom_range(0, 1)); rs = 2'($urandom_range(0, 3));
        end
        default: begin
          v = 1'b1; rw = 1'($urandom_range(0, 3) != 0); mw = 1'b0; rs = 2'b01;
        end
      endcase
      issue(v, rw, mw, rs, f3, rd, a, wd, pc4, rdv, k);
    end

    @(posedge clk);
    #1;
    ValidM = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM pipeline stage of the RV32I core. It sits directly downstream of the EX stage and consumes its EX/MEM register outputs.
- Performs RV32I loads and stores over a ready/valid data-memory bus, with byte-lane steering and load sign/zero extension.
- Stalls the pipeline on wait states and detects misaligned accesses and bus timeouts.
- Registers the MEM/WB state that feeds writeback.

Parameters:
MAX_WAIT, 16, cycles a request may wait for dmem_ready before it terminates as a bus error (legal range 1..255).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
ValidM  in  1  EX/MEM entry holds a real instruction (0 = bubble)
RegWriteM  in  1  register write enable from EX/MEM
MemWriteM  in  1  store request from EX/MEM
ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4; 01 marks a load
Funct3M  in  3  load/store size and sign
RD_M  in  5  destination register
ALU_ResultM  in  32  effective address, or ALU result
WriteDataM  in  32  store data (already forwarded)
PCPlus4M  in  32  PC+4
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address, {ALU_ResultM[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid when dmem_ready=1
dmem_ready  in  1  access completes this cycle
StallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
RegWriteW  out  1  registered
ResultSrcW  out  2  registered
RD_W  out  5  registered
ALU_ResultW  out  32  registered
ReadDataW  out  32  registered, extended load data
PCPlus4W  out  32  registered
MisalignW  out  1  registered; instruction was a misaligned access
BusErrW  out  1  registered; instruction timed out on the bus

Behaviour:
- Access condition: acc = ValidM & (MemWriteM | ResultSrcM==01).
- Misalignment: mis = acc & ((half access & addr[0]) | (word access & addr[1:0]!=0)).
- FSM has two states, IDLE and WAIT. There is also a wait counter wcnt of 8 bits.
- Bus drive: dmem_req = acc & ~mis & ~rst, in both states. dmem_we/addr/be/wdata are driven combinationally from the stage inputs.
- Upstream holds all stage inputs stable while StallM=1.
- IDLE, request with dmem_ready=1: zero-wait completion, StallM=0.
- IDLE, request with dmem_ready=0: go to WAIT, set wcnt=1, StallM=1.
- WAIT, dmem_ready=1: completion, StallM=0, return to IDLE, wcnt=0.
- WAIT, dmem_ready=0 and wcnt==MAX_WAIT-1: timeout completion. StallM=0, return to IDLE, BusErrW=1 next cycle, RegWriteW=0.
- WAIT, otherwise: wcnt+1, StallM=1.
- If dmem_ready and the timeout coincide, ready wins (normal completion).
- Misaligned access: no request, StallM=0. Next cycle MisalignW=1, RegWriteW=0; the remaining fields pass through.
- Store byte enables:
  - SB: be = 0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: be = 0011<<addr[1:0], wdata = {2{wd[15:0]}}.
  - SW: be = 1111, wdata = wd.
- Loads: dmem_be=1111. The selected lane is extended:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - Other Funct3 values on a memory access behave as LW/SW.
- MEM/WB register update on every rising edge:
  - StallM=1: load a bubble (RegWriteW=0, ResultSrcW=00, MisalignW=0, BusErrW=0, data fields hold).
  - StallM=0: capture the stage outputs.
  - Non-memory instruction: ReadDataW = 0.
- Latency: one cycle from stage inputs to W outputs when there are zero wait states; N+1 cycles with N wait states.
- Reset (async, active-high):
  - State goes to IDLE and wcnt to 0.
  - Every registered output goes to 0.
  - dmem_req and StallM are forced to 0 while rst=1.
  - Reset mid-WAIT abandons the request, with no completion and no error flag.

Test Plan:
- SW, addr 0x100, wd 0xDEADBEEF, ready=1 same cycle -> dmem_req=1, we=1, be=1111, addr=0x100, StallM=0; next cycle RegWriteW=0.
- LB, addr 0x203, rdata 0x80FF_FF7F, ready=1 -> ReadDataW=0xFFFFFF80. LBU, same inputs -> 0x00000080. LHU at 0x202 -> 0x000080FF.
- SH, addr 0x12, wd 0x0000ABCD -> be=1100, wdata=0xABCDABCD.
- LW with ready low for 3 cycles -> StallM=1 for 3 cycles, W bubbles for those cycles, then ReadDataW=rdata and RegWriteW=1 once.
- LW, addr 0x106 -> dmem_req=0, StallM=0, MisalignW=1, RegWriteW=0. Also MAX_WAIT=4 with ready never asserted -> StallM high for 3 cycles, then BusErrW=1, state IDLE.
- rst asserted during WAIT -> dmem_req=0 immediately, all W outputs 0. After rst deasserts a new LW completes normally.
